// File: rtl/eth_tx_arb_pkg.sv
// Shared types and sizing helpers for the eth_tx round-robin arbiter.
package eth_tx_arb_pkg;

    typedef enum logic [2:0] {
        ST_IDLE, ST_START, ST_HEAD, ST_DATA, ST_DRAIN, ST_GAP
    } state_t;

    // Default sizing of the arbiter.
    localparam int REQ_N_DFLT   = 4;
    localparam int IFG_CYC_DFLT = 6;
    localparam int WD_CYC_DFLT  = 1024;

    // Counter/index width that stays >= 1 for degenerate sizes.
    function automatic int cnt_w(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/eth_tx_arb_rr_arb.sv
// Combinational rotating-priority picker: first requester after ptr, cyclically.
module rr_arb #(
    parameter int N    = 4,
    parameter int ID_W = 2
) (
    input  logic [N-1:0]    req,
    input  logic [ID_W-1:0] ptr,
    output logic [N-1:0]    gnt,
    output logic [ID_W-1:0] idx,
    output logic            found
);
    always_comb begin
        int k;
        gnt   = '0;
        idx   = '0;
        found = 1'b0;
        k     = 0;
        for (int i = 1; i <= N; i++) begin
            k = (int'(ptr) + i) % N;
            if (!found && req[k]) begin
                found  = 1'b1;
                gnt[k] = 1'b1;
                idx    = ID_W'(k);
            end
        end
    end
endmodule

// File: rtl/eth_tx_arb.sv
// Round-robin scheduler sharing one eth_tx pipe between REQ_N app streams,
// with inter-frame gap enforcement and a per-frame watchdog.
module eth_tx_arb
    import eth_tx_arb_pkg::*;
#(
    parameter int REQ_N      = REQ_N_DFLT,
    parameter int DATA_W     = 16,
    parameter int KEEP_W     = DATA_W / 8,
    parameter int LEN_W      = $clog2(KEEP_W + 1),
    parameter int PKT_LEN_W  = 16,
    parameter int BLOCK_N    = 8,
    parameter int LAST_LEN_W = $clog2(BLOCK_N + KEEP_W + 1),
    parameter int IFG_CYC    = IFG_CYC_DFLT,
    parameter int WD_CYC     = WD_CYC_DFLT
) (
    input  logic                        clk,
    input  logic                        nreset,
    input  logic [REQ_N-1:0]            req_v_i,
    input  logic [REQ_N*PKT_LEN_W-1:0]  req_pkt_len_i,
    input  logic [REQ_N-1:0]            req_cancel_i,
    input  logic [REQ_N*DATA_W-1:0]     req_data_i,
    input  logic [REQ_N*LEN_W-1:0]      req_len_i,
    input  logic [REQ_N-1:0]            req_last_i,
    input  logic [REQ_N-1:0]            req_last_block_next_i,
    input  logic [REQ_N*LAST_LEN_W-1:0] req_last_block_next_len_i,
    output logic [REQ_N-1:0]            grant_o,
    output logic [REQ_N-1:0]            req_ready_o,
    output logic                        tx_early_v_o,
    output logic                        tx_cancel_o,
    output logic [PKT_LEN_W-1:0]        tx_pkt_len_o,
    output logic [DATA_W-1:0]           tx_data_o,
    output logic [LEN_W-1:0]            tx_len_o,
    output logic                        tx_last_o,
    output logic                        tx_last_block_next_o,
    output logic [LAST_LEN_W-1:0]       tx_last_block_next_len_o,
    input  logic                        tx_app_ready_i,
    input  logic                        tx_idle_i
);
    localparam int ID_W     = cnt_w(REQ_N);
    localparam int GAP_W    = cnt_w(IFG_CYC);
    localparam int WD_W     = cnt_w(WD_CYC);
    localparam int GAP_LOAD = (IFG_CYC > 0) ? IFG_CYC - 1 : 0;

    state_t                 state_q, state_d;
    logic [REQ_N-1:0]       grant_q, grant_d, pick_gnt;
    logic [ID_W-1:0]        ptr_q, pick_idx;
    logic                   pick_any;
    logic [GAP_W-1:0]       gap_q;
    logic [WD_W-1:0]        wd_q;
    logic [PKT_LEN_W-1:0]   pkt_len_q, pick_len;
    logic                   active, go_grant, beat_ok, cancel_hit, wd_hit;

    rr_arb #(.N(REQ_N), .ID_W(ID_W)) u_rr (
        .req   (req_v_i),
        .ptr   (ptr_q),
        .gnt   (pick_gnt),
        .idx   (pick_idx),
        .found (pick_any)
    );

    // AND-OR mux: a zero grant forces the whole tx bus to zero.
    always_comb begin
        tx_data_o                = '0;
        tx_len_o                 = '0;
        tx_last_o                = 1'b0;
        tx_last_block_next_o     = 1'b0;
        tx_last_block_next_len_o = '0;
        pick_len                 = '0;
        for (int i = 0; i < REQ_N; i++) begin
            if (grant_q[i]) begin
                tx_data_o                |= req_data_i[i*DATA_W +: DATA_W];
                tx_len_o                 |= req_len_i[i*LEN_W +: LEN_W];
                tx_last_o                |= req_last_i[i];
                tx_last_block_next_o     |= req_last_block_next_i[i];
                tx_last_block_next_len_o |= req_last_block_next_len_i[i*LAST_LEN_W +: LAST_LEN_W];
            end
            if (pick_gnt[i])
                pick_len |= req_pkt_len_i[i*PKT_LEN_W +: PKT_LEN_W];
        end
    end

    assign active       = (state_q == ST_START) || (state_q == ST_HEAD) || (state_q == ST_DATA);
    assign go_grant     = (state_q == ST_IDLE) && pick_any && (gap_q == '0);
    // HEAD with ready already behaves as DATA, so that beat is accepted too.
    assign beat_ok      = tx_app_ready_i && ((state_q == ST_DATA) || (state_q == ST_HEAD));
    assign cancel_hit   = active && |(req_cancel_i & grant_q);
    assign wd_hit       = ((state_q == ST_HEAD) || (state_q == ST_DATA)) && (wd_q == WD_W'(WD_CYC - 1));
    assign tx_cancel_o  = cancel_hit || wd_hit;
    assign tx_early_v_o = (state_q == ST_START);
    assign req_ready_o  = grant_q & {REQ_N{beat_ok}};
    assign grant_o      = grant_q;
    assign tx_pkt_len_o = pkt_len_q;

    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        case (state_q)
            ST_IDLE:  if (go_grant) begin
                          state_d = ST_START;
                          grant_d = pick_gnt;
                      end
            ST_START: state_d = ST_HEAD;
            ST_HEAD:  if (tx_app_ready_i) state_d = tx_last_o ? ST_DRAIN : ST_DATA;
            ST_DATA:  if (tx_app_ready_i && tx_last_o) state_d = ST_DRAIN;
            ST_DRAIN: if (tx_idle_i) begin
                          state_d = (IFG_CYC == 0) ? ST_IDLE : ST_GAP;
                          grant_d = '0;
                      end
            ST_GAP:   if (gap_q == '0) state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
        // Cancel (own or watchdog) overrides any last-beat transition.
        if (tx_cancel_o) begin
            state_d = (IFG_CYC == 0) ? ST_IDLE : ST_GAP;
            grant_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (!nreset) begin
            state_q   <= ST_IDLE;
            grant_q   <= '0;
            ptr_q     <= ID_W'(REQ_N - 1);
            gap_q     <= '0;
            wd_q      <= '0;
            pkt_len_q <= '0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            if (go_grant) begin
                ptr_q     <= pick_idx;
                pkt_len_q <= pick_len;
            end
            if (state_d == ST_GAP && state_q != ST_GAP)
                gap_q <= GAP_W'(GAP_LOAD);
            else if (state_q == ST_GAP && gap_q != '0)
                gap_q <= gap_q - 1'b1;
            if (state_q == ST_START)
                wd_q <= '0;
            else if (state_q == ST_HEAD || state_q == ST_DATA)
                wd_q <= wd_q + 1'b1;
        end
    end
endmodule
